isp_restart_marker_writer: RTL



---
 rtl/isp_restart_marker_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/isp_restart_marker_writer.sv
// Writes a 4-byte restart marker record into TPSRAM, reads it back and verifies it,
// then raises a level restart request; failed verifies retry a bounded number of times.
module isp_restart_marker_writer #(
  parameter logic [5:0]  BASE_ADDR  = 6'd0,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_RETRY  = 2,
  parameter logic [7:0]  MAGIC0     = 8'hA5,
  parameter logic [7:0]  MAGIC1     = 8'h5A
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       i_isp_done,
  input  logic [7:0] i_image_idx,
  input  logic       i_restart_ack,
  input  logic [7:0] i_TPSRAM_RD_sv,
  output logic       o_TPSRAM_WEN,
  output logic [5:0] o_TPSRAM_WADDR_sv,
  output logic [7:0] o_TPSRAM_WD,
  output logic       o_TPSRAM_REN,
  output logic [5:0] o_TPSRAM_RADDR_sv,
  output logic       o_busy,
  output logic       o_restart_req,
  output logic       o_error,
  output logic [1:0] o_attempts
);

  localparam logic [1:0] MaxAttempts = 2'(MAX_RETRY + 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StReq, StError} state_e;

  state_e     r_state, w_state;
  logic [1:0] r_cnt, w_cnt;
  logic [7:0] r_idx, w_idx;
  logic [1:0] r_attempts, w_attempts;
  logic       r_wen, w_wen;
  logic [5:0] r_waddr, w_waddr;
  logic [7:0] r_wd, w_wd;
  logic       r_ren, w_ren;
  logic [5:0] r_raddr, w_raddr;
  logic       r_mismatch, w_mismatch;

  // Read-tag pipeline: a tag issued with REN lines up with RD exactly RD_LATENCY edges later.
  logic [RD_LATENCY-1:0] r_pv;
  logic [1:0]            r_pt [RD_LATENCY];
  logic                  w_cmp_vld;
  logic [1:0]            w_cmp_tag;
  logic                  w_cmp_bad;

  function automatic logic [7:0] rec_byte(input logic [1:0] k, input logic [7:0] idx);
    case (k)
      2'd0:    return MAGIC0;
      2'd1:    return MAGIC1;
      2'd2:    return idx;
      default: return ~(MAGIC0 ^ MAGIC1 ^ idx);
    endcase
  endfunction

  assign w_cmp_vld = r_pv[RD_LATENCY-1];
  assign w_cmp_tag = r_pt[RD_LATENCY-1];
  assign w_cmp_bad = w_cmp_vld && (i_TPSRAM_RD_sv != rec_byte(w_cmp_tag, r_idx));

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_idx      = r_idx;
    w_attempts = r_attempts;
    w_wen      = 1'b0;
    w_waddr    = r_waddr;
    w_wd       = r_wd;
    w_ren      = 1'b0;
    w_raddr    = r_raddr;
    w_mismatch = r_mismatch | w_cmp_bad;
    unique case (r_state)
      StIdle: begin
        if (i_isp_done) begin
          w_idx      = i_image_idx;
          w_attempts = 2'd1;
          w_state    = StWrite;
          w_cnt      = 2'd0;
          w_wen      = 1'b1;
          w_waddr    = BASE_ADDR;
          w_wd       = MAGIC0;
          w_mismatch = 1'b0;
        end
      end
      StWrite: begin
        if (r_cnt != 2'd3) begin
          w_cnt   = r_cnt + 2'd1;
          w_wen   = 1'b1;
          w_waddr = BASE_ADDR + {4'd0, w_cnt};
          w_wd    = rec_byte(w_cnt, r_idx);
        end else begin
          w_state = StRead;
          w_cnt   = 2'd0;
          w_ren   = 1'b1;
          w_raddr = BASE_ADDR;
        end
      end
      StRead: begin
        if (r_cnt != 2'd3) begin
          w_cnt   = r_cnt + 2'd1;
          w_ren   = 1'b1;
          w_raddr = BASE_ADDR + {4'd0, w_cnt};
        end else begin
          w_state = StDrain;
        end
      end
      StDrain: begin
        if (w_cmp_vld && (w_cmp_tag == 2'd3)) begin
          if (!w_mismatch) begin
            w_state = StReq;
          end else if (r_attempts < MaxAttempts) begin
            // Retry reuses the record latched at acceptance.
            w_attempts = r_attempts + 2'd1;
            w_state    = StWrite;
            w_cnt      = 2'd0;
            w_wen      = 1'b1;
            w_waddr    = BASE_ADDR;
            w_wd       = MAGIC0;
            w_mismatch = 1'b0;
          end else begin
            w_state = StError;
          end
        end
      end
      StReq: begin
        if (i_restart_ack) w_state = StIdle;
      end
      StError: ;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state    <= StIdle;
      r_cnt      <= 2'd0;
      r_idx      <= 8'd0;
      r_attempts <= 2'd0;
      r_wen      <= 1'b0;
      r_waddr    <= 6'd0;
      r_wd       <= 8'd0;
      r_ren      <= 1'b0;
      r_raddr    <= 6'd0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_attempts <= w_attempts;
      r_wen      <= w_wen;
      r_waddr    <= w_waddr;
      r_wd       <= w_wd;
      r_ren      <= w_ren;
      r_raddr    <= w_raddr;
      r_mismatch <= w_mismatch;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pt[i] <= 2'd0;
    end else begin
      r_pv[0] <= r_ren;
      r_pt[0] <= r_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  assign o_TPSRAM_WEN      = r_wen;
  assign o_TPSRAM_WADDR_sv = r_waddr;
  assign o_TPSRAM_WD       = r_wd;
  assign o_TPSRAM_REN      = r_ren;
  assign o_TPSRAM_RADDR_sv = r_raddr;
  assign o_busy            = (r_state == StWrite) || (r_state == StRead) || (r_state == StReq);
  assign o_restart_req     = (r_state == StReq);
  assign o_error           = (r_state == StError);
  assign o_attempts        = r_attempts;

endmodule
